// File: rtl/qubit_gate_sequencer_pkg.sv
// Shared amplitude format, opcodes and FSM encoding for qubit_gate_sequencer.
// `TOTAL_WIDTH / `FRAC_WIDTH may be predefined to change the amplitude format.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 8
`endif

package qubit_gate_sequencer_pkg;
   localparam int AMP_W  = `TOTAL_WIDTH;
   localparam int FRAC_W = `FRAC_WIDTH;

   localparam logic [AMP_W-1:0] AMP_ONE = AMP_W'(1) << FRAC_W;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_X    = 2'b01;
   localparam logic [1:0] OP_Z    = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/qubit_gate_sequencer_pair_gate_unit.sv
// One-cycle registered gate on a complex amplitude pair (i, j).
// Z (saturating negation of j) exists only when QGS_PHASE_GATE_EN is defined.
module pair_gate_unit
   import qubit_gate_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       op,
   input  logic [AMP_W-1:0] in_ir,
   input  logic [AMP_W-1:0] in_ii,
   input  logic [AMP_W-1:0] in_jr,
   input  logic [AMP_W-1:0] in_ji,
   output logic [AMP_W-1:0] out_ir,
   output logic [AMP_W-1:0] out_ii,
   output logic [AMP_W-1:0] out_jr,
   output logic [AMP_W-1:0] out_ji
);
`ifdef QGS_PHASE_GATE_EN
   localparam logic [AMP_W-1:0] AMP_MIN = {1'b1, {(AMP_W-1){1'b0}}};
   localparam logic [AMP_W-1:0] AMP_MAX = ~AMP_MIN;

   // Two's-complement negation, with the one unrepresentable result clamped.
   function automatic logic [AMP_W-1:0] sat_neg(input logic [AMP_W-1:0] x);
      return (x == AMP_MIN) ? AMP_MAX : (~x + AMP_W'(1));
   endfunction
`endif

   logic [AMP_W-1:0] ir_d, ii_d, jr_d, ji_d;
   logic [AMP_W-1:0] ir_q, ii_q, jr_q, ji_q;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      ir_d = in_ir;
      ii_d = in_ii;
      jr_d = in_jr;
      ji_d = in_ji;
      case (op)
         OP_X: begin
            ir_d = in_jr;
            ii_d = in_ji;
            jr_d = in_ir;
            ji_d = in_ii;
         end
`ifdef QGS_PHASE_GATE_EN
         OP_Z: begin
            jr_d = sat_neg(in_jr);
            ji_d = sat_neg(in_ji);
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      if (!rst_n) begin
         ir_q <= '0;
         ii_q <= '0;
         jr_q <= '0;
         ji_q <= '0;
      end else begin
         ir_q <= ir_d;
         ii_q <= ii_d;
         jr_q <= jr_d;
         ji_q <= ji_d;
      end
   end

   assign out_ir = ir_q;
   assign out_ii = ii_q;
   assign out_jr = jr_q;
   assign out_ji = ji_q;
endmodule

// File: rtl/qubit_gate_sequencer.sv
// Applies X/Z gate commands to an internal 2^N complex state vector, one amplitude pair per cycle.
// Define QGS_PHASE_GATE_EN to enable the Z gate; otherwise op=10 is rejected with err.
module qubit_gate_sequencer
   import qubit_gate_sequencer_pkg::*;
#(
   parameter int NUM_QUBITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [2:0]            cmd_target,
   input  logic                  ld_valid,
   input  logic [NUM_QUBITS-1:0] ld_addr,
   input  logic [AMP_W-1:0]      ld_r,
   input  logic [AMP_W-1:0]      ld_i,
   input  logic [NUM_QUBITS-1:0] rd_addr,
   output logic [AMP_W-1:0]      rd_r,
   output logic [AMP_W-1:0]      rd_i,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int DEPTH = 1 << NUM_QUBITS;
   localparam int KW    = NUM_QUBITS - 1;
   localparam logic [KW-1:0] K_LAST = '1;

   logic [1:0]            state_d, state_q;
   logic [KW-1:0]         k_d, k_q;
   logic [1:0]            op_d, op_q;
   logic [2:0]            tgt_d, tgt_q;
   logic                  err_d, err_q;
   logic                  wb_valid_d, wb_valid_q;
   logic [NUM_QUBITS-1:0] wb_i_d, wb_i_q, wb_j_d, wb_j_q;
   logic [AMP_W-1:0]      rd_r_d, rd_r_q, rd_i_d, rd_i_q;
   logic [AMP_W-1:0]      amp_r_d [DEPTH];
   logic [AMP_W-1:0]      amp_i_d [DEPTH];
   logic [AMP_W-1:0]      amp_r_q [DEPTH];
   logic [AMP_W-1:0]      amp_i_q [DEPTH];

   logic                  cmd_illegal;
   logic [NUM_QUBITS-1:0] k_ext, tgt_bit, low_mask, issue_i, issue_j;
   logic [AMP_W-1:0]      g_ir, g_ii, g_jr, g_ji;

   always_comb begin
      cmd_illegal = (cmd_op == OP_RSVD) || ({1'b0, cmd_target} >= 4'(NUM_QUBITS));
`ifndef QGS_PHASE_GATE_EN
      cmd_illegal = cmd_illegal || (cmd_op == OP_Z);
`endif
   end

   // Pair k: insert a 0 at the target bit position for i, set it for j.
   always_comb begin
      k_ext    = {1'b0, k_q};
      tgt_bit  = NUM_QUBITS'(1) << tgt_q;
      low_mask = tgt_bit - NUM_QUBITS'(1);
      issue_i  = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
      issue_j  = issue_i | tgt_bit;
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      op_d       = op_q;
      tgt_d      = tgt_q;
      err_d      = err_q;
      wb_valid_d = (state_q == ST_ISSUE);
      wb_i_d     = issue_i;
      wb_j_d     = issue_j;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d  = cmd_op;
               tgt_d = cmd_target;
               k_d   = '0;
               err_d = cmd_illegal;
               if (cmd_illegal || cmd_op == OP_NOP) state_d = ST_DONE;
               else                                 state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (k_q == K_LAST) state_d = ST_DRAIN;
            else               k_d = k_q + KW'(1);
         end
         ST_DRAIN: state_d = ST_DONE;
         default: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end
      endcase
   end

   pair_gate_unit u_gate (
      .clk    (clk),
      .rst_n  (rst_n),
      .op     (op_q),
      .in_ir  (amp_r_q[issue_i]),
      .in_ii  (amp_i_q[issue_i]),
      .in_jr  (amp_r_q[issue_j]),
      .in_ji  (amp_i_q[issue_j]),
      .out_ir (g_ir),
      .out_ii (g_ii),
      .out_jr (g_jr),
      .out_ji (g_ji)
   );

   // Loads happen only in IDLE and writebacks only after ISSUE, so they never collide.
   always_comb begin
      amp_r_d = amp_r_q;
      amp_i_d = amp_i_q;
      if (ld_valid && state_q == ST_IDLE) begin
         amp_r_d[ld_addr] = ld_r;
         amp_i_d[ld_addr] = ld_i;
      end
      if (wb_valid_q) begin
         amp_r_d[wb_i_q] = g_ir;
         amp_i_d[wb_i_q] = g_ii;
         amp_r_d[wb_j_q] = g_jr;
         amp_i_d[wb_j_q] = g_ji;
      end
      rd_r_d = amp_r_q[rd_addr];
      rd_i_d = amp_i_q[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         op_q       <= OP_NOP;
         tgt_q      <= '0;
         err_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_i_q     <= '0;
         wb_j_q     <= '0;
         rd_r_q     <= '0;
         rd_i_q     <= '0;
         // NOTE: the vector is a flop array rather than a RAM because reset must restore |0...0>.
         for (int a = 0; a < DEPTH; a++) begin
            amp_r_q[a] <= (a == 0) ? AMP_ONE : '0;
            amp_i_q[a] <= '0;
         end
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         op_q       <= op_d;
         tgt_q      <= tgt_d;
         err_q      <= err_d;
         wb_valid_q <= wb_valid_d;
         wb_i_q     <= wb_i_d;
         wb_j_q     <= wb_j_d;
         rd_r_q     <= rd_r_d;
         rd_i_q     <= rd_i_d;
         amp_r_q    <= amp_r_d;
         amp_i_q    <= amp_i_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign err       = (state_q == ST_DONE) && err_q;
   assign rd_r      = rd_r_q;
   assign rd_i      = rd_i_q;
endmodule

// File: tb/tb_qubit_gate_sequencer.sv
// Directed self-checking bench for qubit_gate_sequencer (N=3, 16-bit amplitudes, 8 fractional bits).
// Expectations follow QGS_PHASE_GATE_EN the same way the design does.
module tb_qubit_gate_sequencer;
   import qubit_gate_sequencer_pkg::*;

   localparam int N = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic [1:0]       cmd_op = OP_NOP;
   logic [2:0]       cmd_target = '0;
   logic             ld_valid = 1'b0;
   logic [N-1:0]     ld_addr = '0;
   logic [AMP_W-1:0] ld_r = '0;
   logic [AMP_W-1:0] ld_i = '0;
   logic [N-1:0]     rd_addr = '0;
   logic [AMP_W-1:0] rd_r, rd_i;
   logic             cmd_ready, busy, done, err;

   int checks = 0;
   int failures = 0;

   qubit_gate_sequencer #(.NUM_QUBITS(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_target (cmd_target),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_r       (ld_r),
      .ld_i       (ld_i),
      .rd_addr    (rd_addr),
      .rd_r       (rd_r),
      .rd_i       (rd_i),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_amp(input string tag, input int a, input int exp_re, input int exp_im);
      int re, im;
      @(negedge clk);
      rd_addr = N'(a);
      @(negedge clk);
      re = int'($signed(rd_r));
      im = int'($signed(rd_i));
      check($sformatf("%s_amp%0d_re", tag, a), re, exp_re);
      check($sformatf("%s_amp%0d_im", tag, a), im, exp_im);
   endtask

   task automatic load_amp(input int a, input int re, input int im);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_addr  = N'(a);
      ld_r     = AMP_W'(re);
      ld_i     = AMP_W'(im);
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   // Offers one command at cycle 0; optionally pulses a load at cycle ld_cyc (-1 = none).
   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] tgt,
                          input int exp_done, input int exp_err, input int exp_busy,
                          input int ld_cyc, input int ld_a, input int ld_re, input int ld_im);
      int done_cyc, err_seen, busy_cnt;
      done_cyc = -1;
      err_seen = 0;
      busy_cnt = 0;
      @(negedge clk);
      check({tag, "_ready"}, int'(cmd_ready), 1);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_target = tgt;
      if (ld_cyc == 0) begin
         ld_valid = 1'b1;
         ld_addr  = N'(ld_a);
         ld_r     = AMP_W'(ld_re);
         ld_i     = AMP_W'(ld_im);
      end
      for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         ld_valid  = 1'b0;
         if (cyc == 1) check({tag, "_ready_low"}, int'(cmd_ready), (exp_done == 1) ? 0 : 0);
         if (done) begin
            done_cyc = cyc;
            err_seen = int'(err);
            check({tag, "_busy_at_done"}, int'(busy), 0);
         end else if (busy) begin
            busy_cnt++;
         end
         if (cyc == ld_cyc) begin
            ld_valid = 1'b1;
            ld_addr  = N'(ld_a);
            ld_r     = AMP_W'(ld_re);
            ld_i     = AMP_W'(ld_im);
         end
      end
      check({tag, "_done_cycle"}, done_cyc, exp_done);
      check({tag, "_err"}, err_seen, exp_err);
      check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
   endtask

   initial begin
      int exp2_re, exp2_im;
      int done_seen;

      // Reset and |000>
      repeat (2) @(negedge clk);
      check("rst_rd_r", int'(rd_r), 0);
      check("rst_rd_i", int'(rd_i), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_ready", int'(cmd_ready), 1);
      rst_n = 1'b1;
      for (int a = 0; a < 8; a++) check_amp("reset", a, (a == 0) ? 256 : 0, 0);

      // X on qubit 0 moves |000> to |001>
      run_cmd("x_t0", OP_X, 3'd0, 6, 0, 5, -1, 0, 0, 0);
      check_amp("x_t0", 0, 0, 0);
      check_amp("x_t0", 1, 256, 0);

      // X on qubit 2 over a ramp: amp[k] = (k^4, -(k^4))
      for (int k = 0; k < 8; k++) load_amp(k, k, -k);
      run_cmd("x_t2", OP_X, 3'd2, 6, 0, 5, -1, 0, 0, 0);
      for (int k = 0; k < 8; k++) check_amp("x_t2", k, k ^ 4, -(k ^ 4));

      // Z on qubit 1 (amp1 stays (5,-5) from the ramp)
      load_amp(2, 100, -50);
      load_amp(0, 7, 3);
      load_amp(3, -32768, 5);
`ifdef QGS_PHASE_GATE_EN
      run_cmd("z_t1", OP_Z, 3'd1, 6, 0, 5, -1, 0, 0, 0);
      exp2_re = -100;
      exp2_im = 50;
      check_amp("z_t1", 3, 32767, -5);
`else
      run_cmd("z_off", OP_Z, 3'd1, 1, 1, 0, -1, 0, 0, 0);
      exp2_re = 100;
      exp2_im = -50;
      check_amp("z_off", 3, -32768, 5);
`endif
      check_amp("z", 2, exp2_re, exp2_im);
      check_amp("z", 0, 7, 3);

      // Illegal commands and NOP leave the vector alone
      run_cmd("tgt5", OP_X, 3'd5, 1, 1, 0, -1, 0, 0, 0);
      check_amp("tgt5", 2, exp2_re, exp2_im);
      run_cmd("rsvd", OP_RSVD, 3'd0, 1, 1, 0, -1, 0, 0, 0);
      check_amp("rsvd", 0, 7, 3);
      run_cmd("tgt3", OP_X, 3'd3, 1, 1, 0, -1, 0, 0, 0);
      run_cmd("nop", OP_NOP, 3'd0, 1, 0, 0, -1, 0, 0, 0);
      check_amp("nop", 0, 7, 3);

      // Load in the acceptance cycle is seen by the command
      run_cmd("ld_same", OP_X, 3'd0, 6, 0, 5, 0, 0, 11, 22);
      check_amp("ld_same", 1, 11, 22);
      check_amp("ld_same", 0, 5, -5);

      // Load while busy (after pair 0 is written back) is ignored
      run_cmd("ld_busy", OP_X, 3'd0, 6, 0, 5, 4, 0, 99, 99);
      check_amp("ld_busy", 0, 11, 22);
      check_amp("ld_busy", 1, 5, -5);

      // Reset mid-command: no done, vector back to |000>
      done_seen = 0;
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_op     = OP_X;
      cmd_target = 3'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (done) done_seen++;
      @(negedge clk);
      if (done) done_seen++;
      @(negedge clk);
      if (done) done_seen++;
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready", int'(cmd_ready), 1);
      check("abort_busy", int'(busy), 0);
      repeat (8) begin
         if (done) done_seen++;
         @(negedge clk);
      end
      check("abort_no_done", done_seen, 0);
      for (int a = 0; a < 8; a++) check_amp("abort", a, (a == 0) ? 256 : 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
